// File: rtl/ls_pilot_estimator_if.sv
`default_nettype none
// ============================================================================
//  Module      : ls_pilot_estimator_if
//  Description : Bundle for the LS pilot estimator. Carries the incoming
//                pilot stream (sf_start, pilot_valid/pilot_ready, y_r, y_i,
//                nrs_bits) and the outgoing estimate set (est_valid/est_ready,
//                E1..E4 real/imag, pilot_cnt, overflow).
//                master : environment side (drives pilots, accepts sets)
//                slave  : estimator side
//  Revision    : 1.0 - initial release
// ============================================================================
interface ls_pilot_estimator_if #(
    parameter int Y_WIDTH = 16,
    parameter int E_WIDTH = 17
);
    logic                      sf_start;
    logic                      pilot_valid;
    logic                      pilot_ready;
    logic signed [Y_WIDTH-1:0] y_r;
    logic signed [Y_WIDTH-1:0] y_i;
    logic [1:0]                nrs_bits;
    logic                      est_valid;
    logic                      est_ready;
    logic signed [E_WIDTH-1:0] E1_r, E2_r, E3_r, E4_r;
    logic signed [E_WIDTH-1:0] E1_i, E2_i, E3_i, E4_i;
    logic [1:0]                pilot_cnt;
    logic                      overflow;

    modport master (
        output sf_start, pilot_valid, y_r, y_i, nrs_bits, est_ready,
        input  pilot_ready, est_valid, pilot_cnt, overflow,
        input  E1_r, E2_r, E3_r, E4_r, E1_i, E2_i, E3_i, E4_i
    );

    modport slave (
        input  sf_start, pilot_valid, y_r, y_i, nrs_bits, est_ready,
        output pilot_ready, est_valid, pilot_cnt, overflow,
        output E1_r, E2_r, E3_r, E4_r, E1_i, E2_i, E3_i, E4_i
    );
endinterface
`default_nettype wire

// File: rtl/ls_pilot_estimator.sv
`default_nettype none
// ============================================================================
//  Module      : ls_pilot_estimator
//  Description : Least-squares pilot estimator. Each accepted pilot Y is
//                multiplied by conj(X) of its QPSK symbol (add/subtract only),
//                saturated to E_WIDTH bits and stored in E1..E4. A complete
//                set is held with est_valid until est_ready accepts it.
//                E_WIDTH must equal Y_WIDTH+1.
//  Ports       : clk, rst (sync, active-high)
//                bus (slave modport of ls_pilot_estimator_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module ls_pilot_estimator #(
    parameter int Y_WIDTH = 16,
    parameter int E_WIDTH = 17
) (
    input  wire logic            clk,
    input  wire logic            rst,
    ls_pilot_estimator_if.slave  bus
);
    // Working width: one guard bit above E_WIDTH so the sum of two negated
    // full-scale inputs is representable before clamping.
    localparam int c_sw = E_WIDTH + 1;
    localparam logic signed [c_sw-1:0] c_e_max = c_sw'((1 << (E_WIDTH - 1)) - 1);
    localparam logic signed [c_sw-1:0] c_e_min = c_sw'(-(1 << (E_WIDTH - 1)));

    localparam logic [0:0] c_collect = 1'b0;
    localparam logic [0:0] c_hold    = 1'b1;

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic                      w_pilot_ready;
    logic                      w_est_valid;
    logic [1:0]                r_cnt;
    logic                      r_overflow;
    logic signed [E_WIDTH-1:0] r_e_r [4];
    logic signed [E_WIDTH-1:0] r_e_i [4];

    logic signed [c_sw-1:0]    w_yr;
    logic signed [c_sw-1:0]    w_yi;
    logic signed [c_sw-1:0]    w_a_yr;
    logic signed [c_sw-1:0]    w_b_yi;
    logic signed [c_sw-1:0]    w_a_yi;
    logic signed [c_sw-1:0]    w_b_yr;
    logic signed [c_sw-1:0]    w_sum_r;
    logic signed [c_sw-1:0]    w_sum_i;
    logic signed [E_WIDTH-1:0] w_est_r;
    logic signed [E_WIDTH-1:0] w_est_i;
    logic                      w_accept;
    logic [1:0]                w_wr_idx;

    function automatic logic signed [E_WIDTH-1:0] sat(input logic signed [c_sw-1:0] v);
        if (v > c_e_max)
            return c_e_max[E_WIDTH-1:0];
        else if (v < c_e_min)
            return c_e_min[E_WIDTH-1:0];
        else
            return v[E_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Datapath: E = Y * conj(X), X = a + jb, a/b = +-1 from nrs_bits
    //   E_r = a*y_r + b*y_i,  E_i = a*y_i - b*y_r
    // ------------------------------------------------------------------
    assign w_yr   = {{(c_sw - Y_WIDTH){bus.y_r[Y_WIDTH-1]}}, bus.y_r};
    assign w_yi   = {{(c_sw - Y_WIDTH){bus.y_i[Y_WIDTH-1]}}, bus.y_i};
    assign w_a_yr = bus.nrs_bits[0] ? -w_yr : w_yr;
    assign w_a_yi = bus.nrs_bits[0] ? -w_yi : w_yi;
    assign w_b_yi = bus.nrs_bits[1] ? -w_yi : w_yi;
    assign w_b_yr = bus.nrs_bits[1] ? -w_yr : w_yr;
    assign w_sum_r = w_a_yr + w_b_yi;
    assign w_sum_i = w_a_yi - w_b_yr;
    assign w_est_r = sat(w_sum_r);
    assign w_est_i = sat(w_sum_i);

    // sf_start restarts the set, so a pilot arriving with it is always
    // taken as E1 regardless of the current state.
    assign w_accept = bus.pilot_valid & (bus.sf_start | w_pilot_ready);
    assign w_wr_idx = bus.sf_start ? 2'd0 : r_cnt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_collect;
        else
            r_state <= w_state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (bus.sf_start) begin
            w_state_nxt = c_collect;
        end else begin
            case (r_state)
                c_collect: if (bus.pilot_valid && (r_cnt == 2'd3)) w_state_nxt = c_hold;
                c_hold:    if (bus.est_ready)                      w_state_nxt = c_collect;
                default:   w_state_nxt = c_collect;
            endcase
        end
    end

    // FSM: outputs decoded from registered state only
    always_comb begin
        w_pilot_ready = 1'b0;
        w_est_valid   = 1'b0;
        case (r_state)
            c_collect: w_pilot_ready = 1'b1;
            c_hold:    w_est_valid   = 1'b1;
            default:   w_pilot_ready = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, estimate registers and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 2'd0;
            r_overflow <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_e_r[k] <= '0;
                r_e_i[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_e_r[w_wr_idx] <= w_est_r;
                r_e_i[w_wr_idx] <= w_est_i;
            end
            // The 4th pilot wraps the 2-bit count back to 0 naturally.
            if (bus.sf_start)
                r_cnt <= bus.pilot_valid ? 2'd1 : 2'd0;
            else if (w_accept)
                r_cnt <= r_cnt + 2'd1;

            if (bus.sf_start)
                r_overflow <= 1'b0;
            else if (bus.pilot_valid && !w_pilot_ready)
                r_overflow <= 1'b1;
        end
    end

    assign bus.pilot_ready = w_pilot_ready;
    assign bus.est_valid   = w_est_valid;
    assign bus.pilot_cnt   = r_cnt;
    assign bus.overflow    = r_overflow;
    assign bus.E1_r = r_e_r[0];
    assign bus.E2_r = r_e_r[1];
    assign bus.E3_r = r_e_r[2];
    assign bus.E4_r = r_e_r[3];
    assign bus.E1_i = r_e_i[0];
    assign bus.E2_i = r_e_i[1];
    assign bus.E3_i = r_e_i[2];
    assign bus.E4_i = r_e_i[3];
endmodule
`default_nettype wire

// File: tb/tb_ls_pilot_estimator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls_pilot_estimator
//  Description : Self-checking bench for ls_pilot_estimator. Directed cases
//                (basic LS, saturation, backpressure, abort, reset in HOLD)
//                plus a random pilot stream, all compared against a
//                behavioural model of the estimator's transfer rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_pilot_estimator;
    localparam int Y_WIDTH = 16;
    localparam int E_WIDTH = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ls_pilot_estimator_if #(.Y_WIDTH(Y_WIDTH), .E_WIDTH(E_WIDTH)) bus ();

    ls_pilot_estimator #(.Y_WIDTH(Y_WIDTH), .E_WIDTH(E_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic signed [E_WIDTH-1:0] dut_r [4];
    logic signed [E_WIDTH-1:0] dut_i [4];
    assign dut_r[0] = bus.E1_r;
    assign dut_r[1] = bus.E2_r;
    assign dut_r[2] = bus.E3_r;
    assign dut_r[3] = bus.E4_r;
    assign dut_i[0] = bus.E1_i;
    assign dut_i[1] = bus.E2_i;
    assign dut_i[2] = bus.E3_i;
    assign dut_i[3] = bus.E4_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the set being collected/held
    int m_cnt;
    bit m_hold;
    bit m_ovf;
    int m_er [4];
    int m_ei [4];

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int clamp(input int v);
        int hi = (1 << (E_WIDTH - 1)) - 1;
        int lo = -(1 << (E_WIDTH - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Y * conj(X) with X = a + jb
    function automatic void ls_est(input int yr, input int yi, input bit [1:0] bits,
                                   output int er, output int ei);
        int a = bits[0] ? -1 : 1;
        int b = bits[1] ? -1 : 1;
        er = clamp(a * yr + b * yi);
        ei = clamp(a * yi - b * yr);
    endfunction

    function automatic void model_reset();
        m_cnt  = 0;
        m_hold = 1'b0;
        m_ovf  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_er[k] = 0;
            m_ei[k] = 0;
        end
    endfunction

    function automatic void model_step(input bit r, input bit sf, input bit pv,
                                       input bit [1:0] bits, input int yr, input int yi,
                                       input bit rdy);
        int er, ei;
        ls_est(yr, yi, bits, er, ei);
        if (r) begin
            model_reset();
            return;
        end
        if (sf) begin
            m_hold = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 0;
            if (pv) begin
                m_er[0] = er;
                m_ei[0] = ei;
                m_cnt   = 1;
            end
            return;
        end
        if (!m_hold) begin
            if (pv) begin
                m_er[m_cnt] = er;
                m_ei[m_cnt] = ei;
                m_cnt++;
                if (m_cnt == 4) begin
                    m_cnt  = 0;
                    m_hold = 1'b1;
                end
            end
        end else begin
            if (pv)  m_ovf  = 1'b1;
            if (rdy) m_hold = 1'b0;
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pilot_ready"}, bus.pilot_ready, !m_hold);
        chk({tag, ".est_valid"},   bus.est_valid,   m_hold);
        chk({tag, ".pilot_cnt"},   bus.pilot_cnt,   m_cnt);
        chk({tag, ".overflow"},    bus.overflow,    m_ovf);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.E%0d_r", tag, k + 1), dut_r[k], m_er[k]);
            chk($sformatf("%s.E%0d_i", tag, k + 1), dut_i[k], m_ei[k]);
        end
    endtask

    // One clock cycle: drive inputs, advance model, sample #1 after the edge
    task automatic cycle(input string tag, input bit r, input bit sf, input bit pv,
                         input bit [1:0] bits, input int yr, input int yi, input bit rdy);
        rst             = r;
        bus.sf_start    = sf;
        bus.pilot_valid = pv;
        bus.nrs_bits    = bits;
        bus.y_r         = Y_WIDTH'(yr);
        bus.y_i         = Y_WIDTH'(yi);
        bus.est_ready   = rdy;
        model_step(r, sf, pv, bits, yr, yi, rdy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic int rand_y();
        logic signed [Y_WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = {1'b1, {(Y_WIDTH-1){1'b0}}};
            1:       v = {1'b0, {(Y_WIDTH-1){1'b1}}};
            default: v = Y_WIDTH'($urandom);
        endcase
        return int'(v);
    endfunction

    int basic_r [4] = '{150, -50, 50, -150};
    int basic_i [4] = '{-50, -150, 150, 50};

    initial begin
        int accepted;
        int cycles;
        bit pv;

        model_reset();
        cycle("reset", 1, 0, 0, 2'd0, 0, 0, 0);
        cycle("reset", 1, 0, 0, 2'd0, 0, 0, 0);
        chk("reset_ready", bus.pilot_ready, 1);
        chk("reset_valid", bus.est_valid, 0);

        // Basic LS, est_ready held high
        for (int k = 0; k < 4; k++)
            cycle("basic", 0, 0, 1, 2'(k), 100, 50, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("basic_E%0d_r", k + 1), dut_r[k], basic_r[k]);
            chk($sformatf("basic_E%0d_i", k + 1), dut_i[k], basic_i[k]);
        end
        chk("basic_valid_rise", bus.est_valid, 1);
        chk("basic_ready_low", bus.pilot_ready, 0);
        cycle("basic_drain", 0, 0, 0, 2'd0, 0, 0, 1);
        chk("basic_valid_1cyc", bus.est_valid, 0);

        // Saturation corners
        cycle("sat", 0, 0, 1, 2'd3, -32768, -32768, 1);
        cycle("sat", 0, 0, 1, 2'd1, -32768, 32767, 1);
        chk("sat_E1_r", bus.E1_r, 65535);
        chk("sat_E1_i", bus.E1_i, 0);
        chk("sat_E2_r", bus.E2_r, 65535);
        chk("sat_E2_i", bus.E2_i, 1);
        cycle("sat", 0, 0, 1, 2'd0, 32767, 32767, 1);
        cycle("sat", 0, 0, 1, 2'd2, -32768, 32767, 1);
        chk("sat_E3_r", bus.E3_r, 65534);
        chk("sat_E4_r", bus.E4_r, -65535);
        cycle("sat_drain", 0, 0, 0, 2'd0, 0, 0, 1);

        // Backpressure: hold 10 cycles, one illegal pilot in the middle
        for (int k = 0; k < 4; k++)
            cycle("bp_fill", 0, 0, 1, 2'($urandom), rand_y(), rand_y(), 0);
        for (int k = 0; k < 10; k++)
            cycle("bp_hold", 0, 0, (k == 4), 2'd1, 1234, -4321, 0);
        chk("bp_ready_low", bus.pilot_ready, 0);
        chk("bp_overflow", bus.overflow, 1);
        cycle("bp_release", 0, 0, 0, 2'd0, 0, 0, 1);
        chk("bp_valid_drop", bus.est_valid, 0);
        chk("bp_ovf_sticky", bus.overflow, 1);

        // Abort: clear, two pilots, then sf_start together with a pilot
        cycle("abort_clr", 0, 1, 0, 2'd0, 0, 0, 0);
        chk("abort_ovf_clr", bus.overflow, 0);
        cycle("abort", 0, 0, 1, 2'd2, 700, -300, 0);
        cycle("abort", 0, 0, 1, 2'd1, -20, 900, 0);
        cycle("abort_sf", 0, 1, 1, 2'd3, 111, 222, 0);
        chk("abort_cnt", bus.pilot_cnt, 1);
        chk("abort_E1_r", bus.E1_r, -333);
        chk("abort_E1_i", bus.E1_i, -111);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_valid", bus.est_valid, 0);
            cycle("abort_fill", 0, 0, 1, 2'(k), rand_y(), rand_y(), 0);
        end
        chk("abort_valid", bus.est_valid, 1);
        cycle("abort_drain", 0, 0, 0, 2'd0, 0, 0, 1);

        // Reset while a set is held
        for (int k = 0; k < 4; k++)
            cycle("rst_fill", 0, 0, 1, 2'($urandom), rand_y(), rand_y(), 0);
        chk("rst_in_hold", bus.est_valid, 1);
        cycle("rst_hold", 1, 0, 0, 2'd0, 0, 0, 0);
        chk("rst_hold_ready", bus.pilot_ready, 1);
        chk("rst_hold_E4_r", bus.E4_r, 0);

        // Random stream honouring pilot_ready
        accepted = 0;
        cycles   = 0;
        while (accepted < 1000 && cycles < 20000) begin
            pv = bus.pilot_ready && ($urandom_range(0, 3) != 0);
            if (pv) accepted++;
            cycle("rand", 0, 0, pv, 2'($urandom), rand_y(), rand_y(),
                  1'($urandom_range(0, 1)));
            cycles++;
        end
        chk("rand_accepted", accepted, 1000);
        chk("rand_no_overflow", bus.overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
